// File: rtl/crc_pkg.sv
// ----------------------------------------------------------------------------
// crc_pkg
// Shared definitions for the CRC stream checker and its generator partner.
//   state_t    : checker FSM states (IDLE, SHIFT, DONE)
//   CRC32_POLY : standard CRC-32 generator, bit 32 = x^32
//   crc_step   : one MSB-first mod-2 division step of width w
// ----------------------------------------------------------------------------
package crc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam int CRC_MAX_W = 64;

  localparam logic [32:0] CRC32_POLY = 33'h104C11DB7;

  // The step is computed at CRC_MAX_W bits so one function serves any width
  // up to 64; callers zero-extend their operands and truncate the result.
  // The x^w term of the generator is implicit: the bit leaving the top of
  // the remainder decides whether the low w bits of the polynomial apply.
  function automatic logic [CRC_MAX_W-1:0] crc_step(
    input logic [CRC_MAX_W-1:0] r,
    input logic                 b,
    input logic [CRC_MAX_W-1:0] poly,
    input int unsigned          w
  );
    logic [CRC_MAX_W-1:0] nxt;
    nxt = (r << 1) | CRC_MAX_W'(b);
    if (r[w-1]) begin
      nxt = nxt ^ poly;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/crc_stream_checker_if.sv
// ----------------------------------------------------------------------------
// crc_stream_checker_if
// Valid/ready word stream carrying a frame whose last word is the CRC.
//   s_data  : stream data word
//   s_valid : s_data / s_last valid
//   s_last  : current word is the frame's CRC word
//   s_ready : sink can accept a word
// Modports: master (stream source), slave (checker).
// ----------------------------------------------------------------------------
interface crc_stream_checker_if #(
  parameter int WIDTH = 32
);

  logic [WIDTH-1:0] s_data;
  logic             s_valid;
  logic             s_last;
  logic             s_ready;

  modport master (
    output s_data,
    output s_valid,
    output s_last,
    input  s_ready
  );

  modport slave (
    input  s_data,
    input  s_valid,
    input  s_last,
    output s_ready
  );

endinterface

// File: rtl/crc_div_serial.sv
// ----------------------------------------------------------------------------
// crc_div_serial
// Bit-serial MSB-first polynomial divider. A word loaded with 'load' is
// shifted into the running remainder one bit per cycle over WIDTH cycles.
// The remainder accumulates across words until 'clear'.
//   clk, rst  : clock, async active-high reset
//   load      : capture 'word' and start shifting
//   clear     : zero the remainder (end of frame)
//   word      : data word to divide
//   poly      : generator polynomial without the implicit x^WIDTH term
//   busy      : a word is being shifted
//   done      : high in the cycle whose edge shifts the word's final bit
//   remainder : running remainder
// ----------------------------------------------------------------------------
module crc_div_serial
  import crc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] word,
  input  logic [WIDTH-1:0] poly,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] remainder
);

  localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] r;
  logic [BIT_W-1:0] bit_cnt;
  logic             busy_q;

  assign busy      = busy_q;
  assign done      = busy_q && (bit_cnt == LAST_BIT);
  assign remainder = r;

  // Shift register feeds its MSB into the remainder each busy cycle; the
  // remainder is only ever cleared explicitly so it spans a whole frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr      <= '0;
      r       <= '0;
      bit_cnt <= '0;
      busy_q  <= 1'b0;
    end else if (clear) begin
      r       <= '0;
      bit_cnt <= '0;
      busy_q  <= 1'b0;
    end else if (load) begin
      sr      <= word;
      bit_cnt <= '0;
      busy_q  <= 1'b1;
    end else if (busy_q) begin
      sr      <= {sr[WIDTH-2:0], 1'b0};
      r       <= WIDTH'(crc_step(CRC_MAX_W'(r), sr[WIDTH-1],
                                 CRC_MAX_W'(poly), WIDTH));
      bit_cnt <= bit_cnt + 1'b1;
      if (bit_cnt == LAST_BIT) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/crc_stream_checker.sv
// ----------------------------------------------------------------------------
// crc_stream_checker
// Receive-side CRC check of a framed word stream whose last word is the
// transmitter-appended CRC. Reports pass/fail once per frame.
//   clk, rst   : clock, async active-high reset
//   s          : stream input (slave modport): s_data, s_valid, s_last, s_ready
//   polynom_i  : generator polynomial, bit WIDTH = x^WIDTH
//   frame_done : one-cycle end-of-frame pulse
//   crc_ok     : remainder zero, valid with frame_done
//   crc_err    : remainder non-zero, valid with frame_done
//   rem_o      : final remainder of the last frame, held
//   word_cnt   : words in the last frame including the CRC word, held
// ----------------------------------------------------------------------------
module crc_stream_checker
  import crc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  crc_stream_checker_if.slave  s,
  input  logic [WIDTH:0]       polynom_i,
  output logic                 frame_done,
  output logic                 crc_ok,
  output logic                 crc_err,
  output logic [WIDTH-1:0]     rem_o,
  output logic [CNT_W-1:0]     word_cnt
);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] poly_q;
  logic             last_q;
  logic [CNT_W-1:0] frame_cnt;
  logic             xfer;
  logic             div_done;
  logic [WIDTH-1:0] div_rem;
  logic             unused_div_busy;
  logic             unused_poly_msb;

  // The x^WIDTH term is implied by the divider and never stored.
  assign unused_poly_msb = polynom_i[WIDTH];

  assign s.s_ready = (state == IDLE);
  assign xfer      = s.s_valid && s.s_ready;

  crc_div_serial #(
    .WIDTH (WIDTH)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .load      (xfer),
    .clear     (state == DONE),
    .word      (s.s_data),
    .poly      (poly_q),
    .busy      (unused_div_busy),
    .done      (div_done),
    .remainder (div_rem)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The polynomial is captured only on a frame's first word so a source
  // changing it mid-frame cannot corrupt the division in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      poly_q    <= '0;
      last_q    <= 1'b0;
      frame_cnt <= '0;
      rem_o     <= '0;
      word_cnt  <= '0;
    end else if (xfer) begin
      last_q <= s.s_last;
      if (frame_cnt == '0) begin
        poly_q <= polynom_i[WIDTH-1:0];
      end
      if (frame_cnt != '1) begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end else if (state == DONE) begin
      rem_o     <= div_rem;
      word_cnt  <= frame_cnt;
      frame_cnt <= '0;
    end
  end

  always_comb begin
    state_next = state;
    frame_done = 1'b0;
    crc_ok     = 1'b0;
    crc_err    = 1'b0;
    case (state)
      IDLE: begin
        if (xfer) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (div_done) begin
          state_next = last_q ? DONE : IDLE;
        end
      end
      DONE: begin
        frame_done = 1'b1;
        crc_ok     = (div_rem == '0);
        crc_err    = (div_rem != '0);
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_crc_stream_checker.sv
// ----------------------------------------------------------------------------
// tb_crc_stream_checker
// Self-checking bench for crc_stream_checker with a frame scoreboard.
// ----------------------------------------------------------------------------
module tb_crc_stream_checker;
  import crc_pkg::*;

  localparam int WIDTH = 32;
  localparam int CNT_W = 16;

  typedef struct {
    logic             ok;
    logic [WIDTH-1:0] rem;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic             clk;
  logic             rst;
  logic [WIDTH:0]   polynom_i;
  logic             frame_done;
  logic             crc_ok;
  logic             crc_err;
  logic [WIDTH-1:0] rem_o;
  logic [CNT_W-1:0] word_cnt;

  crc_stream_checker_if #(.WIDTH(WIDTH)) bus ();

  crc_stream_checker #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s          (bus),
    .polynom_i  (polynom_i),
    .frame_done (frame_done),
    .crc_ok     (crc_ok),
    .crc_err    (crc_err),
    .rem_o      (rem_o),
    .word_cnt   (word_cnt)
  );

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   accept_cyc = 0;
  int   xfer_cnt = 0;
  int   gap = 0;
  int   gap_expect = 0;
  bit   tracking = 0;
  bit   hold_pending = 0;
  exp_t hold_exp;
  exp_t sb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference mod-2 long division over a word sequence, 33-bit working form.
  function automatic logic [WIDTH-1:0] refRemainder(input logic [WIDTH-1:0] w[$],
                                                    input logic [WIDTH:0] poly);
    logic [WIDTH:0] acc;
    acc = '0;
    foreach (w[i]) begin
      for (int b = WIDTH - 1; b >= 0; b--) begin
        acc = {acc[WIDTH-1:0], w[i][b]};
        if (acc[WIDTH]) acc = acc ^ poly;
      end
    end
    return acc[WIDTH-1:0];
  endfunction

  // Monitor: handshake gaps, frame_done latency and scoreboard comparison.
  always @(negedge clk) begin
    if (rst) begin
      tracking     = 0;
      hold_pending = 0;
    end else begin
      if (hold_pending) begin
        checkOutput("rem_o", 64'(rem_o), 64'(hold_exp.rem));
        checkOutput("word_cnt", 64'(word_cnt), 64'(hold_exp.cnt));
        hold_pending = 0;
      end
      if (tracking && bus.s_ready) begin
        checkOutput("ready_gap", 64'(gap), 64'(gap_expect));
        tracking = 0;
      end
      if (bus.s_valid && bus.s_ready) begin
        xfer_cnt++;
        accept_cyc = cyc + 1;
        gap_expect = bus.s_last ? WIDTH + 1 : WIDTH;
        gap        = 0;
        tracking   = 1;
      end else if (tracking) begin
        gap++;
      end
      if (frame_done) begin
        checks++;
        assert (sb.size() > 0)
        else begin
          errors++;
          $error("[TB] FAIL unexpected_done observed=1 expected=0");
        end
        if (sb.size() > 0) begin
          hold_exp = sb.pop_front();
          checkOutput("crc_ok", 64'(crc_ok), 64'(hold_exp.ok));
          checkOutput("crc_err", 64'(crc_err), 64'(!hold_exp.ok));
          checkOutput("done_latency", 64'(cyc - accept_cyc), 64'(WIDTH));
          hold_pending = 1;
        end
      end else begin
        checkOutput("flags_idle", 64'({crc_ok, crc_err}), 64'(0));
      end
    end
  end

  // Present one word and hold it until it transfers.
  task automatic applyStimulus(input logic [WIDTH-1:0] data, input logic last);
    int n;
    bus.s_valid = 1'b1;
    bus.s_data  = data;
    bus.s_last  = last;
    n = 0;
    while (!bus.s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) checkOutput("ready_timeout", 64'(n), 64'(0));
    @(negedge clk);
  endtask

  task automatic sendFrame(input logic [WIDTH-1:0] w[$], input exp_t e,
                           input logic [WIDTH:0] poly,
                           input logic [WIDTH:0] alt_poly,
                           input bit keep_valid);
    polynom_i = poly;
    sb.push_back(e);
    foreach (w[i]) begin
      applyStimulus(w[i], i == w.size() - 1);
      if (i == 0) polynom_i = alt_poly;
      if (!keep_valid) bus.s_valid = 1'b0;
    end
    polynom_i = poly;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while ((sb.size() != 0 || hold_pending) && n < 400) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain", 64'(sb.size()), 64'(0));
  endtask

  logic [WIDTH-1:0] frm[$];
  logic [WIDTH-1:0] data4[$];
  exp_t             e;
  int               x0;

  initial begin
    rst         = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    polynom_i   = CRC32_POLY;
    repeat (3) @(negedge clk);
    checkOutput("rst_ready", 64'(bus.s_ready), 64'(1));
    checkOutput("rst_done", 64'(frame_done), 64'(0));
    checkOutput("rst_rem", 64'(rem_o), 64'(0));
    checkOutput("rst_cnt", 64'(word_cnt), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] single-word frame");
    frm = '{32'h00000000};
    e = '{ok: 1'b1, rem: 32'h0, cnt: 16'd1};
    sendFrame(frm, e, CRC32_POLY, CRC32_POLY, 0);
    waitDrain();

    $display("[TB] two-word good frame");
    frm = '{32'h00000001, 32'h04C11DB7};
    e = '{ok: 1'b1, rem: 32'h0, cnt: 16'd2};
    sendFrame(frm, e, CRC32_POLY, CRC32_POLY, 0);
    waitDrain();

    $display("[TB] corrupted CRC");
    frm = '{32'h00000001, 32'h04C11DB6};
    e = '{ok: 1'b0, rem: 32'h1, cnt: 16'd2};
    sendFrame(frm, e, CRC32_POLY, CRC32_POLY, 0);
    waitDrain();

    $display("[TB] four-word frame with s_valid held");
    data4 = '{32'h12345678, 32'hDEADBEEF, 32'hCAFEF00D, 32'h00000000};
    frm   = '{32'h12345678, 32'hDEADBEEF, 32'hCAFEF00D,
              refRemainder(data4, CRC32_POLY)};
    e = '{ok: 1'b1, rem: refRemainder(frm, CRC32_POLY), cnt: 16'd4};
    checkOutput("model_good", 64'(e.rem), 64'(0));
    x0 = xfer_cnt;
    sendFrame(frm, e, CRC32_POLY, CRC32_POLY, 1);
    bus.s_valid = 1'b0;
    waitDrain();
    checkOutput("xfer_count", 64'(xfer_cnt - x0), 64'(4));

    $display("[TB] four-word frame, polynomial changed mid-frame");
    sendFrame(frm, e, CRC32_POLY, 33'h1000000AF, 1);
    bus.s_valid = 1'b0;
    waitDrain();

    $display("[TB] back-to-back frames");
    frm = '{32'h00000001, 32'h04C11DB7};
    e = '{ok: 1'b1, rem: 32'h0, cnt: 16'd2};
    sendFrame(frm, e, CRC32_POLY, CRC32_POLY, 1);
    frm = '{32'h00000001, 32'h04C11DB6};
    e = '{ok: 1'b0, rem: 32'h1, cnt: 16'd2};
    sendFrame(frm, e, CRC32_POLY, CRC32_POLY, 1);
    bus.s_valid = 1'b0;
    waitDrain();

    $display("[TB] reset mid-shift");
    applyStimulus(32'hA5A5A5A5, 1'b0);
    bus.s_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_ready", 64'(bus.s_ready), 64'(1));
    checkOutput("abort_rem", 64'(rem_o), 64'(0));
    checkOutput("abort_cnt", 64'(word_cnt), 64'(0));
    checkOutput("abort_done", 64'(frame_done), 64'(0));
    rst = 1'b0;
    repeat (40) @(negedge clk);

    frm = '{32'h00000001, 32'h04C11DB7};
    e = '{ok: 1'b1, rem: 32'h0, cnt: 16'd2};
    sendFrame(frm, e, CRC32_POLY, CRC32_POLY, 0);
    waitDrain();
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
